eu_sequencer: RTL and testbench

Multi-cycle execution-unit controller that sequences the 8-bit ALU in the EU. It owns a small register file, accepts one instruction at a time over a valid/ready handshake, and drives the ALU opcode and operand ports from registers. It captures the ALU result, writes it back to the destination register and updates zero/negative flags. It sits between instruction decode and the combinational ALU; the ALU is instantiated outside and wired to the `alu_*` ports.

---
 rtl/eu_sequencer.sv | 113 +++++++++++
 tb/tb_eu_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/eu_sequencer.sv
// eu_sequencer
//   Multi-cycle controller that sequences the external combinational 8-bit ALU.
//   It accepts one instruction at a time and owns a small register file. Each
//   instruction steps through IDLE -> READ -> EXEC -> WB. Operands are
//   registered onto the alu_* ports. The ALU result is captured one cycle later
//   and then written back with a zero/negative flag update.
//
// Ports
//   clk, rst          : clock; asynchronous active-high reset
//   instr_valid/ready : instruction handshake (ready only in IDLE, low in reset)
//   instr_op/rd/rs/imm: opcode, destination (= operand A source), operand B
//                       source, immediate (operand A for LDI)
//   alu_opcode/a/b    : registered ALU inputs, held between instructions
//   alu_result        : combinational result coming back from the ALU
//   done              : one-cycle retire pulse
//   flag_z, flag_n    : zero / sign of the last retired non-NOP result
//   dbg_addr/dbg_data : combinational register-file peek
module eu_sequencer #(
  parameter int REG_AW = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [3:0]        instr_op,
  input  logic [REG_AW-1:0] instr_rd,
  input  logic [REG_AW-1:0] instr_rs,
  input  logic [7:0]        instr_imm,
  output logic [3:0]        alu_opcode,
  output logic [7:0]        alu_a,
  output logic [7:0]        alu_b,
  input  logic [7:0]        alu_result,
  output logic              done,
  output logic              flag_z,
  output logic              flag_n,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [7:0]        dbg_data
);

  localparam int        NREG   = 1 << REG_AW;
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'hF;

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  typedef struct packed {
    logic [3:0]        op;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs;
    logic [7:0]        imm;
  } instr_t;

  state_t                 state;
  instr_t                 ir;
  logic [7:0]             res;
  logic [NREG-1:0][7:0]   rf;

  // Ready is gated by rst directly so it drops the moment reset is applied,
  // not at the next edge.
  assign instr_ready = (state == IDLE) && !rst;
  assign dbg_data    = rf[dbg_addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ir         <= '0;
      res        <= 8'h00;
      rf         <= '0;
      alu_opcode <= 4'h0;
      alu_a      <= 8'h00;
      alu_b      <= 8'h00;
      done       <= 1'b0;
      flag_z     <= 1'b0;
      flag_n     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (instr_valid) begin
            ir.op  <= instr_op;
            ir.rd  <= instr_rd;
            ir.rs  <= instr_rs;
            ir.imm <= instr_imm;
            state  <= READ;
          end
        end
        READ: begin
          // Both operands come from the register file as it stood before this
          // instruction, so rd==rs reads the same old value twice.
          alu_opcode <= ir.op;
          alu_a      <= (ir.op == OP_LDI) ? ir.imm : rf[ir.rd];
          alu_b      <= rf[ir.rs];
          state      <= EXEC;
        end
        EXEC: begin
          res   <= alu_result;
          state <= WB;
        end
        WB: begin
          if (ir.op != OP_NOP) begin
            rf[ir.rd] <= res;
            flag_z    <= (res == 8'h00);
            flag_n    <= res[7];
          end
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eu_sequencer.sv
module tb_eu_sequencer;
  localparam int AW = 2;
  localparam int NR = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          instr_valid = 1'b0;
  logic          instr_ready;
  logic [3:0]    instr_op = '0;
  logic [AW-1:0] instr_rd = '0;
  logic [AW-1:0] instr_rs = '0;
  logic [7:0]    instr_imm = '0;
  logic [3:0]    alu_opcode;
  logic [7:0]    alu_a, alu_b, alu_result;
  logic          done, flag_z, flag_n;
  logic [AW-1:0] dbg_addr = '0;
  logic [7:0]    dbg_data;

  always #5 clk = ~clk;

  eu_sequencer #(.REG_AW(AW)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs(instr_rs), .instr_imm(instr_imm),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .done(done), .flag_z(flag_z), .flag_n(flag_n),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Environment ALU (lives outside the sequencer).
  function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      4'h1: return a + b;
      4'h2: return a - b;
      4'h3: return a & b;
      4'h4: return a | b;
      4'h5: return a ^ b;
      4'h6: return a + 8'h01;
      4'h7: return a - 8'h01;
      4'h8: return ~a;
      4'h9: return a << 1;
      4'hA: return a >> 1;
      4'hB: return {a[6:0], a[7]};
      4'hC: return {a[0], a[7:1]};
      4'hD: return b;
      default: return a;
    endcase
  endfunction
  assign alu_result = alu_f(alu_opcode, alu_a, alu_b);

  int checks = 0;
  int passed = 0;

  // Reference model: architectural register file, flags, and in-flight list.
  logic [7:0] mr [NR];
  logic       mz, mn;
  typedef struct {
    int done_at;
    logic [3:0] op;
    logic [AW-1:0] rd;
    logic [7:0] a, b, res;
  } pend_t;
  pend_t pq[$];
  int cyc = 0;
  int last_acc = -100;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic chk_regs(input string tag);
    for (int i = 0; i < NR; i++) begin
      dbg_addr = i[AW-1:0];
      #1;
      chk($sformatf("%s_r%0d", tag, i), {24'd0, dbg_data}, {24'd0, mr[i]});
    end
  endtask

  task automatic chk_reg(input int idx, input logic [7:0] exp);
    dbg_addr = idx[AW-1:0];
    #1;
    chk($sformatf("direct_r%0d", idx), {24'd0, dbg_data}, {24'd0, exp});
  endtask

  // One cycle: check outputs at the negedge, then drive the next inputs.
  task automatic step(input logic v, input logic [3:0] op, input logic [AW-1:0] rd,
                      input logic [AW-1:0] rs, input logic [7:0] imm);
    logic exp_rdy, exp_done;
    pend_t p;
    @(negedge clk);
    cyc++;
    exp_rdy  = (cyc - last_acc) > 3;
    exp_done = (pq.size() > 0) && (pq[0].done_at == cyc);
    chk("ready", {31'd0, instr_ready}, {31'd0, exp_rdy});
    chk("done", {31'd0, done}, {31'd0, exp_done});
    if (pq.size() > 0 && pq[0].done_at - 2 == cyc) begin
      chk("alu_op", {28'd0, alu_opcode}, {28'd0, pq[0].op});
      chk("alu_a", {24'd0, alu_a}, {24'd0, pq[0].a});
      chk("alu_b", {24'd0, alu_b}, {24'd0, pq[0].b});
    end
    if (exp_done) begin
      p = pq.pop_front();
      if (p.op != 4'h0) begin
        mr[p.rd] = p.res;
        mz = (p.res == 8'h00);
        mn = p.res[7];
      end
      chk("flag_z", {31'd0, flag_z}, {31'd0, mz});
      chk("flag_n", {31'd0, flag_n}, {31'd0, mn});
      chk_regs("wb");
    end
    instr_valid = v;
    instr_op = op; instr_rd = rd; instr_rs = rs; instr_imm = imm;
    if (exp_rdy && v) begin
      p.done_at = cyc + 4;
      p.op = op; p.rd = rd;
      p.a = (op == 4'hF) ? imm : mr[rd];
      p.b = mr[rs];
      p.res = alu_f(op, p.a, p.b);
      pq.push_back(p);
      last_acc = cyc;
    end
  endtask

  task automatic junk_step();
    step($urandom_range(0, 1) == 1, 4'($urandom), AW'($urandom), AW'($urandom), 8'($urandom));
  endtask

  // Present an instruction until accepted, then run it to retirement while
  // toggling garbage on the instruction inputs.
  task automatic send(input logic [3:0] op, input logic [AW-1:0] rd,
                      input logic [AW-1:0] rs, input logic [7:0] imm);
    int tries = 0;
    do begin
      step(1'b1, op, rd, rs, imm);
      tries++;
    end while (last_acc != cyc && tries < 8);
    if (last_acc != cyc) chk("accept_timeout", 32'd0, 32'd1);
    repeat (3) junk_step();
    step(1'b0, 4'h0, '0, '0, 8'h00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_ready", {31'd0, instr_ready}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_alu_op", {28'd0, alu_opcode}, 32'd0);
    chk("rst_alu_a", {24'd0, alu_a}, 32'd0);
    chk("rst_alu_b", {24'd0, alu_b}, 32'd0);
    chk("rst_flags", {30'd0, flag_z, flag_n}, 32'd0);
    for (int i = 0; i < NR; i++) mr[i] = 8'h00;
    mz = 1'b0; mn = 1'b0;
    pq.delete();
    last_acc = -100;
    @(posedge clk);
    #1;
    chk_regs("rst");
    @(negedge clk);
    rst = 1'b0;
    instr_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NR; i++) mr[i] = 8'h00;
    mz = 1'b0; mn = 1'b0;

    do_reset();
    repeat (2) step(1'b0, 4'h0, '0, '0, 8'h00);

    // LDI/ADD with negative result
    send(4'hF, 2'd1, 2'd0, 8'h7F);
    send(4'hF, 2'd2, 2'd0, 8'h01);
    send(4'h1, 2'd1, 2'd2, 8'h00);
    chk_reg(1, 8'h80);
    chk("add_n", {31'd0, flag_n}, 32'd1);
    chk("add_z", {31'd0, flag_z}, 32'd0);

    // Zero and wrap
    send(4'h2, 2'd1, 2'd1, 8'h00);
    chk_reg(1, 8'h00);
    chk("sub_z", {31'd0, flag_z}, 32'd1);
    send(4'hF, 2'd0, 2'd0, 8'h00);
    send(4'h7, 2'd0, 2'd0, 8'h00);
    chk_reg(0, 8'hFF);
    chk("dec_n", {31'd0, flag_n}, 32'd1);
    chk("dec_z", {31'd0, flag_z}, 32'd0);

    // NOP: no write, flags hold
    send(4'h0, 2'd2, 2'd1, 8'hAA);
    chk_reg(2, 8'h01);
    chk("nop_flags", {30'd0, flag_z, flag_n}, 32'b01);

    // Self-rewrite and doubling with rd==rs
    send(4'hE, 2'd2, 2'd3, 8'h00);
    send(4'h1, 2'd2, 2'd2, 8'h00);
    chk_reg(2, 8'h02);

    // Back-to-back: valid held high, fields changing every cycle
    repeat (40) step(1'b1, 4'($urandom), AW'($urandom), AW'($urandom), 8'($urandom));
    repeat (6) step(1'b0, 4'h0, '0, '0, 8'h00);

    // Randomized instructions with random idle gaps
    repeat (30) begin
      send(4'($urandom), AW'($urandom), AW'($urandom), 8'($urandom));
      repeat ($urandom_range(0, 2)) step(1'b0, 4'h0, '0, '0, 8'h00);
    end

    // Reset during EXEC of INC R3
    send(4'hF, 2'd3, 2'd0, 8'h55);
    chk_reg(3, 8'h55);
    begin
      int tries = 0;
      do begin
        step(1'b1, 4'h6, 2'd3, 2'd3, 8'h00);
        tries++;
      end while (last_acc != cyc && tries < 8);
      if (last_acc != cyc) chk("accept_timeout_inc", 32'd0, 32'd1);
    end
    step(1'b0, 4'h0, '0, '0, 8'h00);   // READ
    do_reset();                          // asserted during EXEC
    repeat (5) step(1'b0, 4'h0, '0, '0, 8'h00);
    chk_reg(3, 8'h00);
    send(4'h6, 2'd3, 2'd0, 8'h00);
    chk_reg(3, 8'h01);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
